// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the data-memory responder: FSM state encoding,
//   default parameters and the request-legality rule.
package dmem_responder_pkg;

   localparam int DMEM_LATENCY_DEFAULT = 4;
   localparam int DMEM_ADDR_W_DEFAULT  = 8;
   localparam int DMEM_CNT_W           = 4;   // holds LATENCY-1 for LATENCY up to 15

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10,
      ST_BAD  = 2'b11   // unreachable; recovers to IDLE with an err pulse
   } dmem_state_e;

   // Exactly one of Rd/Wr and a word-aligned address.
   function automatic logic req_valid(input logic rd, input logic wr, input logic a0);
      return (rd ^ wr) & ~a0;
   endfunction

endpackage

// File: rtl/dmem_word_array.sv
// dmem_word_array
//   2^ADDR_W x 16 storage. Synchronous write; synchronous read into a
//   registered output that is cleared by reset (contents are never cleared).
// Ports:
//   clk, rst   clock, synchronous active-high reset (read register only)
//   i_we       write enable, writes i_wdata to i_addr
//   i_re       read enable, loads o_rdata from i_addr
//   i_addr     word index
//   i_wdata    write data
//   o_rdata    registered read data, holds between reads
module dmem_word_array #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [15:0]       i_wdata,
   output logic [15:0]       o_rdata
);

   logic [15:0] r_mem [2**ADDR_W];
   logic [15:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)       r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory responder for the memory stage. Accepts one
//   read or write at a time, holds the pipeline via Stall for LATENCY busy
//   cycles, then pulses Done for one cycle with read data on DataOut.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   Addr       byte address; word index is Addr[ADDR_W:1], upper bits alias
//   DataIn     write data
//   Rd, Wr     level requests, held by the requester until Done
//   DataOut    registered read data (holds last read value)
//   Stall      combinational pipeline hold
//   Done       one-cycle completion pulse (registered)
//   err        one-cycle illegal-request pulse (registered)
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W  = DMEM_ADDR_W_DEFAULT,
   parameter int LATENCY = DMEM_LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Stall,
   output logic        Done,
   output logic        err
);

   localparam logic [DMEM_CNT_W-1:0] LAT_M1 = DMEM_CNT_W'(LATENCY - 1);

   dmem_state_e           r_state, w_state_nxt;
   logic [DMEM_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0]     r_idx;
   logic [15:0]           r_data;
   logic                  r_wr;
   logic                  r_done, w_done_nxt;
   logic                  r_err, w_err_nxt;
   logic                  w_valid, w_illegal, w_latch, w_we, w_re, w_stall;
   logic                  w_unused_addr;

   assign w_valid       = req_valid(Rd, Wr, Addr[0]);
   assign w_illegal     = (Rd | Wr) & ~w_valid;
   assign w_unused_addr = &{1'b0, Addr};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_we        = 1'b0;
      w_re        = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_stall     = 1'b1;
               w_latch     = 1'b1;
               w_cnt_nxt   = LAT_M1;
               w_state_nxt = ST_BUSY;
            end else if (w_illegal) begin
               w_err_nxt   = 1'b1;
            end
         end
         ST_BUSY: begin
            w_stall = 1'b1;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               // access happens on the last busy edge so Done and DataOut
               // appear together in the DONE cycle
               w_we        = r_wr;
               w_re        = ~r_wr;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         // requester still holds Rd/Wr here; ignore it to avoid a re-accept
         ST_DONE: w_state_nxt = ST_IDLE;
         default: begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_data  <= '0;
         r_wr    <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         if (w_latch) begin
            r_idx  <= Addr[ADDR_W:1];
            r_data <= DataIn;
            r_wr   <= Wr;
         end
      end
   end

   // reset during the final busy cycle must not commit the write
   dmem_word_array #(.ADDR_W(ADDR_W)) u_array (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we & ~rst),
      .i_re    (w_re),
      .i_addr  (r_idx),
      .i_wdata (r_data),
      .o_rdata (DataOut)
   );

   assign Stall = w_stall;
   assign Done  = r_done;
   assign err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int L  = 4;
   localparam int AW = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr, din, dout;
   logic        rd, wr, stall, done, err;
   logic [15:0] addr1, din1, dout1;
   logic        rd1, wr1, stall1, done1, err1;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(AW), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .Addr(addr), .DataIn(din), .Rd(rd), .Wr(wr),
      .DataOut(dout), .Stall(stall), .Done(done), .err(err)
   );

   dmem_responder #(.ADDR_W(AW), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .Addr(addr1), .DataIn(din1), .Rd(rd1), .Wr(wr1),
      .DataOut(dout1), .Stall(stall1), .Done(done1), .err(err1)
   );

   int total = 0;
   int bad   = 0;

   // reference model: word store and the last value a read returned
   logic [15:0] mem [256];
   logic [15:0] m_dout;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] din;
      logic [15:0] dout;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   function automatic bit legal(input logic r, input logic w, input logic [15:0] a);
      return ((r ^ w) == 1'b1) && (a[0] == 1'b0);
   endfunction

   // One request on the LATENCY=4 instance, starting just after a rising edge.
   task automatic txn(input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] exp_dout);
      rd = r; wr = w; addr = a; din = d;
      if (legal(r, w, a)) begin
         for (int i = 0; i <= L; i++) begin
            smp;
            chk("stall_busy", {15'd0, stall}, 16'd1);
            chk("done_early", {15'd0, done}, 16'd0);
            chk("err_legal",  {15'd0, err},  16'd0);
            tick;
            addr = 16'($urandom);   // latched values only once busy
            din  = 16'($urandom);
         end
         smp;
         chk("done",       {15'd0, done},  16'd1);
         chk("stall_done", {15'd0, stall}, 16'd0);
         chk("dout",       dout, exp_dout);
         tick;
         rd = 1'b0; wr = 1'b0;
         smp;
         chk("done_once",  {15'd0, done},  16'd0);
         chk("stall_idle", {15'd0, stall}, 16'd0);
         tick;
      end else begin
         smp;
         chk("stall_ill", {15'd0, stall}, 16'd0);
         tick;
         smp;
         chk("err_pulse", {15'd0, err},   16'd1);
         chk("stall_ill", {15'd0, stall}, 16'd0);
         chk("done_ill",  {15'd0, done},  16'd0);
         tick;
         rd = 1'b0; wr = 1'b0;
         smp;
         chk("err_repeat", {15'd0, err}, 16'd1);
         chk("dout_hold",  dout, exp_dout);
         tick;
         smp;
         chk("err_clear", {15'd0, err},  16'd0);
         chk("done_ill",  {15'd0, done}, 16'd0);
         tick;
      end
   endtask

   task automatic mupd(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      if (legal(r, w, a)) begin
         if (w) mem[a[8:1]] = d;
         else   m_dout = mem[a[8:1]];
      end
   endtask

   task automatic mtxn(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      logic [15:0] e;
      e = (legal(r, w, a) && r) ? mem[a[8:1]] : m_dout;
      txn(r, w, a, d, e);
      mupd(r, w, a, d);
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
      tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
      tbl[2] = '{1'b0, 1'b1, 16'h0004, 16'h5A5A, 16'hBEEF};
      tbl[3] = '{1'b1, 1'b1, 16'h0004, 16'h9999, 16'hBEEF};
      tbl[4] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'hBEEF};
      tbl[5] = '{1'b0, 1'b1, 16'h0005, 16'hFFFF, 16'hBEEF};
      tbl[6] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h5A5A};
      tbl[7] = '{1'b0, 1'b1, 16'h0002, 16'h1234, 16'h5A5A};
      tbl[8] = '{1'b1, 1'b0, 16'h0202, 16'h0000, 16'h1234};
      tbl[9] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};

      rst = 1'b1;
      rd = 0; wr = 0; addr = 0; din = 0;
      rd1 = 0; wr1 = 0; addr1 = 0; din1 = 0;
      repeat (3) tick;
      smp;
      chk("rst_dout",  dout, 16'h0000);
      chk("rst_done",  {15'd0, done},  16'd0);
      chk("rst_err",   {15'd0, err},   16'd0);
      chk("rst_stall", {15'd0, stall}, 16'd0);
      tick;
      rst = 1'b0;
      tick;
      m_dout = 16'h0000;

      // directed table
      for (int i = 0; i < 10; i++) begin
         txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].dout);
         mupd(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
      end

      // reset in the second busy cycle of a write
      mtxn(1'b0, 1'b1, 16'h0020, 16'h1111);
      wr = 1'b1; addr = 16'h0020; din = 16'hAAAA;
      smp; chk("abort_stall0", {15'd0, stall}, 16'd1);
      tick;
      smp; chk("abort_stall1", {15'd0, stall}, 16'd1);
      tick;
      rst = 1'b1;
      smp; chk("abort_stall2", {15'd0, stall}, 16'd1);
      tick;
      rst = 1'b0; wr = 1'b0;
      smp;
      chk("abort_done",  {15'd0, done},  16'd0);
      chk("abort_stall", {15'd0, stall}, 16'd0);
      chk("abort_dout",  dout, 16'h0000);
      m_dout = 16'h0000;
      for (int i = 0; i < L + 2; i++) begin
         tick;
         smp;
         chk("abort_nodone", {15'd0, done}, 16'd0);
      end
      tick;
      mtxn(1'b1, 1'b0, 16'h0020, 16'h0000);

      // randomized traffic over 16 aliased words
      for (int i = 0; i < 16; i++) mtxn(1'b0, 1'b1, 16'(i << 1), 16'($urandom));
      for (int n = 0; n < 40; n++) begin
         int idx, kind;
         logic r, w, odd;
         logic [15:0] a;
         idx  = $urandom_range(0, 15);
         kind = $urandom_range(0, 9);
         odd  = ($urandom_range(0, 9) == 0);
         r = (kind == 0) || (kind < 5);
         w = (kind == 0) || (kind >= 5);
         a = 16'(($urandom & 32'h0000FE00) | 32'(idx << 1) | 32'(odd));
         mtxn(r, w, a, 16'($urandom));
      end

      // LATENCY=1 instance: write, then Rd held continuously
      wr1 = 1'b1; addr1 = 16'h0008; din1 = 16'hC0DE;
      for (int n = 0; n < 5; n++) begin
         if (n > 0) begin rd1 = 1'b1; wr1 = 1'b0; end
         addr1 = 16'h0008;
         smp;
         chk("l1_stall_acc",  {15'd0, stall1}, 16'd1);
         chk("l1_done_acc",   {15'd0, done1},  16'd0);
         tick;
         addr1 = 16'($urandom); din1 = 16'($urandom);
         smp;
         chk("l1_stall_busy", {15'd0, stall1}, 16'd1);
         chk("l1_done_busy",  {15'd0, done1},  16'd0);
         tick;
         addr1 = 16'($urandom);
         smp;
         chk("l1_done",       {15'd0, done1},  16'd1);
         chk("l1_stall_done", {15'd0, stall1}, 16'd0);
         chk("l1_dout",       dout1, (n == 0) ? 16'h0000 : 16'hC0DE);
         chk("l1_err",        {15'd0, err1},   16'd0);
         tick;
      end
      rd1 = 1'b0;
      smp;
      chk("l1_done_end", {15'd0, done1}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the processor's memory stage: accepts one read or write request at a time, holds the pipeline with `Stall` for a fixed access latency, then completes with a one-cycle `Done` pulse and read data. It is the memory-side end of the memory stage's Rd/Wr/Addr/DataIn request interface and supplies the pipeline-wide `Stall` source during memory accesses.

## Interface
- `ADDR_W`, 8: word-index width; array depth is 2^ADDR_W 16-bit words.
- `LATENCY`, 4: busy cycles per access; legal range 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `Addr`  in  16  byte address; word index = `Addr[ADDR_W:1]`, upper bits ignored (aliasing).
- `DataIn`  in  16  write data.
- `Rd`  in  1  read request, level; held by requester until `Done`.
- `Wr`  in  1  write request, level; held by requester until `Done`.
- `DataOut`  out  16  registered read data.
- `Stall`  out  1  pipeline hold request (combinational from state and inputs).
- `Done`  out  1  one-cycle completion pulse (registered).
- `err`  out  1  one-cycle illegal-request pulse (registered).

## Operation
- States: IDLE, BUSY, DONE. Reset -> IDLE.
- A request is valid when exactly one of `Rd` or `Wr` is high and `Addr[0]==0`.
- IDLE:
  - On a valid request: latch Addr, DataIn, and op; `cnt <= LATENCY-1`; go to BUSY.
  - On `Rd&Wr` or odd address with a request: `err<=1` next cycle; request ignored; stay IDLE.
  - No request: stay IDLE.
- BUSY: `cnt!=0` -> decrement. `cnt==0` -> perform access:
  - write: `array[idx] <= latched data`
  - read: `DataOut <= array[idx]`
  
  Then go to DONE.
- DONE: `Done=1`. Inputs are ignored, because the requester still holds `Rd`/`Wr` this cycle. Go to IDLE unconditionally.
- `Stall = (IDLE & valid request) | BUSY`. `Stall` is 0 for illegal requests and in DONE.
- Only latched values are used once BUSY; input changes during BUSY have no effect.
- `DataOut` holds the last read value across writes and idle cycles.
- Read-after-write to the same word returns the new value, since accesses are strictly sequential.

## Timing
- Reset values: state IDLE, `cnt` 0, `DataOut` 0x0000, `Done` 0, `err` 0, `Stall` 0. Array contents are not cleared.
- A request sampled in IDLE at cycle k:
  - `Stall` is high in cycles k..k+LATENCY.
  - `Done` is high in cycle k+LATENCY+1.
  - `DataOut` is valid from cycle k+LATENCY+1.
  - Request-to-Done latency is LATENCY+1 cycles.
- Back-to-back: the earliest next acceptance is cycle k+LATENCY+2 (IDLE again). Throughput is one access per LATENCY+2 cycles.
- `err` is asserted in cycle k+1 for an illegal request at k, and repeats every cycle while the illegal request is held.
- `rst` during BUSY aborts the access: no array write, no `Done`, state IDLE next cycle, `DataOut` cleared.
- `rst` during DONE clears `Done` next cycle.
- `LATENCY=1`: BUSY lasts exactly one cycle (`cnt==0` on entry).

## Structure
- Shared package:
  - state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10; 2'b11 is illegal and returns to IDLE with `err` pulse
  - `DMEM_LATENCY_DEFAULT`
  - `DMEM_ADDR_W_DEFAULT`
- One sub-module, `dmem_word_array`: 2^ADDR_W x 16 array with synchronous write enable, synchronous read into an output register with its own read enable.
- The FSM, counter, request latches, and `err`/`Done` registers live in `dmem_responder`.

## Test plan
- Write then read, LATENCY=4:
  - `Wr`, Addr 0x0010, DataIn 0xBEEF at cycle 2 -> `Stall` high cycles 2..6, `Done` at 7.
  - Then `Rd` 0x0010 accepted at 8 -> `Done` at 13 with `DataOut` 0xBEEF; `Stall` 0 in cycles 7 and 13.
- Illegal requests:
  - `Rd&Wr` at 0x0004 -> `err` pulses next cycle, `Stall` 0, no `Done`.
  - `Rd` at 0x0003 -> same.
  - Array unchanged; subsequent read of 0x0004 returns prior value.
- Aliasing, ADDR_W=8:
  - write 0x1234 to 0x0002, then read 0x0202 -> `DataOut` 0x1234.
- Reset mid-access:
  - `Wr` 0x0020 / 0xAAAA, `rst` asserted in the second BUSY cycle -> no `Done`, `DataOut` 0x0000, `Stall` 0 after reset.
  - Later read of 0x0020 returns the old contents (not 0xAAAA).
- LATENCY=1, held request:
  - `Rd` held continuously -> `Done` every 3 cycles; inputs changed during BUSY do not alter the returned word; `Done` never held two consecutive cycles.
